// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers.
package cpu_pipe_pkg;

    localparam int unsigned PC_W_DEF   = 32;
    localparam int unsigned INST_W_DEF = 32;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

    // Occupancy of a 2-entry stage register; the encoding doubles as the occ count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_slot.sv
// Valid-tagged data register with load and clear; clear wins over load.
module pipe_slot #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Clear only drops the valid tag; the data word is kept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register: valid/ready handshake, 2-entry skid buffer,
// stall, branch flush and a saturating bubble counter.
module if_id_skid_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned      PC_W     = PC_W_DEF,
    parameter int unsigned      INST_W   = INST_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF),
    parameter int unsigned      CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc_4,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc_4,
    output logic [INST_W-1:0] out_inst,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int unsigned SLOT_W = PC_W + INST_W;

    occ_e              occ_q;
    occ_e              occ_nxt;
    logic              accept;
    logic              consume;
    logic              main_load;
    logic              main_clr;
    logic              skid_load;
    logic              skid_clr;
    logic              skid_valid;
    logic [SLOT_W-1:0] in_d;
    logic [SLOT_W-1:0] main_d;
    logic [SLOT_W-1:0] main_q;
    logic [SLOT_W-1:0] skid_q;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready & ~stall;
    assign in_d    = {in_pc_4, in_inst};
    // A held skid entry is always older than the incoming word, so it refills main first.
    assign main_d  = skid_valid ? skid_q : in_d;

    always_comb begin
        occ_nxt   = occ_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        case (occ_q)
            OCC_EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    occ_nxt   = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && consume) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    occ_nxt   = OCC_FULL;
                end else if (consume) begin
                    main_clr = 1'b1;
                    occ_nxt  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (consume) begin
                    main_load = 1'b1;
                    skid_clr  = 1'b1;
                    occ_nxt   = OCC_ONE;
                end
            end
            default: occ_nxt = OCC_EMPTY;
        endcase
        // Flush drops everything, including a word accepted this cycle.
        if (flush) begin
            main_load = 1'b0;
            skid_load = 1'b0;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
            occ_nxt   = OCC_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q      <= OCC_EMPTY;
            in_ready   <= 1'b1;
            bubble_cnt <= '0;
        end else begin
            occ_q    <= occ_nxt;
            in_ready <= (occ_nxt != OCC_FULL);
            if (!out_valid && !stall && (bubble_cnt != {CNT_W{1'b1}})) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

    pipe_slot #(.W(SLOT_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clr),
        .d     (main_d),
        .valid (out_valid),
        .q     (main_q)
    );

    pipe_slot #(.W(SLOT_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clr),
        .d     (in_d),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign occ      = occ_q;
    assign out_pc_4 = main_q[SLOT_W-1 -: PC_W];
    assign out_inst = out_valid ? main_q[INST_W-1:0] : NOP_INST;

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Parametrised IF/ID pipeline register for the pipelined CPU.
- Successor to the fixed 32-bit IF/ID latch: adds a valid/ready handshake, a 2-entry skid buffer, stall, branch flush with NOP insertion, and a saturating bubble counter.
- Sits between the IF stage (producer) and the ID stage (consumer).
- Decouples fetch from decode back-pressure without losing or reordering instructions.

Parameters:
- PC_W, 32, width of the pc_4 field.
- INST_W, 32, width of the instruction field.
- NOP_INST, 32'h0000_0000, instruction word driven whenever out_valid=0.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-low.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  register can accept this cycle.
- in_pc_4  in  PC_W  PC+4 of the fetched instruction.
- in_inst  in  INST_W  fetched instruction.
- out_valid  out  1  ID-side entry is valid.
- out_ready  in  1  ID consumes this cycle.
- out_pc_4  out  PC_W  PC+4 of the head entry.
- out_inst  out  INST_W  head instruction, or NOP_INST when invalid.
- stall  in  1  hazard stall from ID; same effect as out_ready=0.
- flush  in  1  branch taken; discard all held and in-flight entries.
- occ  out  2  occupancy, 0..2.
- bubble_cnt  out  CNT_W  saturating count of bubble cycles.

Behaviour:
- Reset: rst=0 at a posedge clears everything:
  - valid bits = 0, occ = 0, bubble_cnt = 0.
  - main and skid data registers = 0.
  - Resulting outputs: out_valid=0, out_inst=NOP_INST, out_pc_4=0, in_ready=1.
  - Reset overrides flush, stall and any transfer in the same cycle.
- Definitions:
  - accept = in_valid & in_ready.
  - consume = out_valid & out_ready & ~stall.
- in_ready = (occ != 2). Registered state only; no combinational path from out_ready or stall.
- State machine on occ:
  - EMPTY(0):
    - accept -> ONE; in_* written to main.
  - ONE(1):
    - accept & consume -> ONE; main <= in_*.
    - accept & ~consume -> FULL; skid <= in_*.
    - consume & ~accept -> EMPTY.
    - neither -> hold.
  - FULL(2):
    - in_ready=0, so accept is impossible.
    - consume -> ONE; main <= skid.
- Ordering: strictly FIFO. The skid entry is always younger than main.
- Output path:
  - out_valid = main valid.
  - out_pc_4 = main pc_4, held unchanged while invalid.
  - out_inst = main inst if valid, else NOP_INST.
- Latency: one cycle from accept into an empty register to out_valid=1.
- Throughput: one instruction per cycle while out_ready=1 and stall=0.
- Flush:
  - Next state is EMPTY, regardless of accept or consume in the same cycle.
  - An input accepted in the flush cycle is dropped; it counts as taken from IF's point of view.
  - in_ready is still driven from current occ during the flush cycle.
  - Data registers are not cleared; out_inst reads NOP_INST via the valid gating.
- Stall:
  - Freezes main and skid; consume=0.
  - Accept is still permitted while occ<2, so the skid absorbs one extra fetch.
- bubble_cnt:
  - Increments when out_valid=0 & stall=0 & rst=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - Not cleared by flush.
- Simultaneous flush & stall: flush wins.
- Simultaneous consume & accept in FULL: cannot occur.

Decomposition:
- Shared package cpu_pipe_pkg:
  - occupancy state constants OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2;
  - the default NOP_INST value;
  - PC_W/INST_W defaults shared with the other stage registers.
- One natural sub-module, pipe_slot: a valid-tagged data register with load/clear, instantiated twice (main and skid).
- Control FSM and counter stay in the top module.

Test Plan:
- Reset then stream: hold rst=0 two cycles, then drive pc_4 = 4, 8, 12 with out_ready=1.
  - Expected: the same values appear one cycle later.
  - Expected: occ stays 1 and in_ready stays 1 throughout.
  - Expected: out_inst = NOP_INST only in the first post-reset cycle.
- Back-pressure: stall=1 while driving pc_4 = 4, 8, 12.
  - Expected: occ goes 1 then 2, and in_ready=0 after the second accept.
  - Expected: pc_4=12 is held by IF.
  - Release stall -> outputs 4, 8, 12 in order, no loss or duplication.
- Flush in FULL: occ=2 holding 0x10 and 0x14; assert flush with in_valid=1, in_pc_4=0x18.
  - Expected next cycle: occ=0, out_valid=0, out_inst=NOP_INST.
  - Expected: 0x18 never appears at the output.
- Flush & stall together at occ=1 -> occ=0 next cycle.
- Bubble counter with CNT_W=4 and in_valid=0 for 20 cycles.
  - Expected: bubble_cnt saturates at 15.
  - Expected: a stall=1 cycle does not increment it.
- Reset mid-operation: occ=2, then rst=0 for one cycle with flush=0 and in_valid=1.
  - Expected: occ=0, bubble_cnt=0, in_ready=1.
  - Expected: the input offered during the reset cycle is not captured.
